alk_mdloop_seq: RTL and testbench

//  Parametrised multiply/divide loop sequencer for the DC615 ALK datapath slice.
//  - Decodes the ALPCTL mul/div group and counts loop iterations.
//  - Drives the loop flag, the shift direction and the last-iteration strobe.
//  - Successor to the ALPCTL combinational decode: adds an iteration counter, a

---
 rtl/alk_mdloop_seq.sv | 187 ++++++++++++++++++
 tb/tb_alk_mdloop_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alk_mdloop_seq.sv
// alk_mdloop_seq: multiply/divide loop sequencer for the ALK datapath slice.
// Decodes the ALPCTL mul/div group and counts loop iterations. It also drives
// the loop flag, the shift direction, the last-iteration strobe and the
// remainder fix-up cycle.
// Build option: define ALK_MDLOOP_EARLY_EN so that a MUL loop ends early when
// the remaining multiplier bits are zero. Without it, every loop runs the full
// N iterations.
//
// Issue handshake: uvalid_h is the only qualifier, and there is no ready. An
// op is taken on a rising edge when all of the following hold: uvalid_h=1,
// alu_0xxx_l=1, stall_h=0, abort_h=0, and the sequencer is IDLE. Microcode
// never issues while busy_h=1, and any such issue is dropped.
module alk_mdloop_seq #(
    parameter int WIDTH     = 32,
    parameter int FAST_BITS = 2,
    parameter int CNT_W     = 6
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic [9:0]       alpctl_h,
    input  logic             alu_0xxx_l,
    input  logic             alu_shl_op_h,
    input  logic             alu_shr_op_h,
    input  logic             uvalid_h,
    input  logic             stall_h,
    input  logic             abort_h,
    input  logic             mdr_zero_h,
    output logic             busy_h,
    output logic             loop_flag_h,
    output logic             last_iter_h,
    output logic             fix_h,
    output logic             shl_op_h,
    output logic             shr_op_h,
    output logic [CNT_W-1:0] iter_cnt_h,
    output logic [1:0]       dbg_state_h
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_LAST = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Iteration counts and the counter values loaded at issue (N-1).
    localparam int N_FAST = WIDTH / FAST_BITS;
    localparam int N_SLOW = WIDTH;
    localparam logic [CNT_W-1:0] LOAD_FAST = CNT_W'(N_FAST - 1);
    localparam logic [CNT_W-1:0] LOAD_SLOW = CNT_W'(N_SLOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_mul_q, op_mul_d;
    logic             op_div_q, op_div_d;

    logic             grp_hit;
    logic             dec_mul;
    logic             dec_div;
    logic             dec_divd;
    logic             dec_rem;
    logic             dec_slow;
    logic             is_idle;
    logic             take;
    logic             issue_md;
    logic             issue_rem;
    logic [CNT_W-1:0] load_val;
    logic             early_stop;

    // Decode the ALPCTL mul/div group. The whole group needs alu_0xxx_l=1.
    always_comb begin
        grp_hit  = alu_0xxx_l && (alpctl_h[9:6] == 4'b1001) && alpctl_h[5];
        dec_mul  = grp_hit && (alpctl_h[3:2] == 2'b10) && alpctl_h[0];
        dec_div  = grp_hit && (alpctl_h[3:2] == 2'b11) && !alpctl_h[0];
        dec_divd = grp_hit && (alpctl_h[3:2] == 2'b11) && (alpctl_h[1:0] == 2'b11);
        dec_rem  = grp_hit && (alpctl_h[4:0] == 5'b01010);
        dec_slow = alpctl_h[1];
    end

    // Issue qualification and the counter preload for the chosen radix.
    always_comb begin
        is_idle   = (state_q == ST_IDLE);
        take      = uvalid_h && !stall_h && !abort_h && is_idle;
        issue_md  = take && (dec_mul || dec_div);
        issue_rem = take && dec_rem;
        load_val  = dec_slow ? LOAD_SLOW : LOAD_FAST;
    end

`ifdef ALK_MDLOOP_EARLY_EN
    // A MUL loop may stop once the remaining multiplier bits are all zero.
    // DIV always runs the full count.
    always_comb begin
        early_stop = op_mul_q && mdr_zero_h;
    end
`else
    logic mdr_zero_unused;
    // Without the early-exit option, mdr_zero_h has no effect.
    always_comb begin
        early_stop      = 1'b0;
        mdr_zero_unused = mdr_zero_h;
    end
`endif

    // Next-state, counter and latched-mode logic.
    // Abort takes priority over stall, and stall takes priority over progress.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_mul_d = op_mul_q;
        op_div_d = op_div_q;
        if (abort_h) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            op_mul_d = 1'b0;
            op_div_d = 1'b0;
        end else if (!stall_h) begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_md) begin
                        op_mul_d = dec_mul;
                        op_div_d = dec_div;
                        cnt_d    = load_val;
                        // A single-iteration configuration skips LOOP entirely.
                        state_d  = (load_val == '0) ? ST_LAST : ST_LOOP;
                    end else if (issue_rem) begin
                        op_mul_d = 1'b0;
                        op_div_d = 1'b0;
                        cnt_d    = '0;
                        state_d  = ST_FIX;
                    end
                end
                ST_LOOP: begin
                    if (early_stop || (cnt_q == CNT_ONE)) begin
                        cnt_d   = '0;
                        state_d = ST_LAST;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_LAST: begin
                    op_mul_d = 1'b0;
                    op_div_d = 1'b0;
                    state_d  = ST_IDLE;
                end
                ST_FIX: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_mul_q <= 1'b0;
            op_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_mul_q <= op_mul_d;
            op_div_q <= op_div_d;
        end
    end

    // Moore status outputs, plus shift requests that merge the ALU pass-through.
    // Stall holds these outputs because it holds the state.
    always_comb begin
        busy_h      = (state_q != ST_IDLE);
        loop_flag_h = (state_q == ST_LOOP);
        last_iter_h = (state_q == ST_LAST);
        fix_h       = (state_q == ST_FIX);
        iter_cnt_h  = cnt_q;
        dbg_state_h = state_q;
        shl_op_h    = alu_shl_op_h
                    | (dec_divd && uvalid_h && is_idle)
                    | (op_div_q && (loop_flag_h || last_iter_h));
        shr_op_h    = alu_shr_op_h
                    | (op_mul_q && (loop_flag_h || last_iter_h));
    end

endmodule

// File: tb/tb_alk_mdloop_seq.sv
// tb_alk_mdloop_seq: directed bench for alk_mdloop_seq at WIDTH=32, FAST_BITS=2.
// A cycle-count model runs alongside the DUT. It tracks how many busy cycles
// remain, and a negedge compare process checks every output against it.
// Directed runs pin the model with hand-derived literal counts.
module tb_alk_mdloop_seq;

    localparam int WIDTH     = 32;
    localparam int FAST_BITS = 2;
    localparam int CNT_W     = 6;
`ifdef ALK_MDLOOP_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk_h = 1'b0;
    logic             reset_h;
    logic [9:0]       alpctl_h;
    logic             alu_0xxx_l;
    logic             alu_shl_op_h;
    logic             alu_shr_op_h;
    logic             uvalid_h;
    logic             stall_h;
    logic             abort_h;
    logic             mdr_zero_h;
    logic             busy_h;
    logic             loop_flag_h;
    logic             last_iter_h;
    logic             fix_h;
    logic             shl_op_h;
    logic             shr_op_h;
    logic [CNT_W-1:0] iter_cnt_h;
    logic [1:0]       dbg_state_h;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    logic [CNT_W-1:0] exp_q[$];

    alk_mdloop_seq #(.WIDTH(WIDTH), .FAST_BITS(FAST_BITS), .CNT_W(CNT_W)) dut (
        .clk_h(clk_h), .reset_h(reset_h), .alpctl_h(alpctl_h), .alu_0xxx_l(alu_0xxx_l),
        .alu_shl_op_h(alu_shl_op_h), .alu_shr_op_h(alu_shr_op_h), .uvalid_h(uvalid_h),
        .stall_h(stall_h), .abort_h(abort_h), .mdr_zero_h(mdr_zero_h), .busy_h(busy_h),
        .loop_flag_h(loop_flag_h), .last_iter_h(last_iter_h), .fix_h(fix_h),
        .shl_op_h(shl_op_h), .shr_op_h(shr_op_h), .iter_cnt_h(iter_cnt_h),
        .dbg_state_h(dbg_state_h)
    );

    // Clock and watchdog.
    always #5 clk_h = ~clk_h;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: remaining busy cycles for the active op.
    int m_rem   = 0;
    bit m_mul   = 1'b0;
    bit m_div   = 1'b0;
    bit m_isrem = 1'b0;
    int m_kind;

    // Op kinds: 0 none, 1 MUL, 2 DIV, 3 DIVD, 4 REM.
    function automatic int op_kind(input logic [9:0] a);
        if (a ==? 10'b1001_1x10_x1) return 1;
        if (a ==? 10'b1001_1x11_11) return 3;
        if (a ==? 10'b1001_1x11_x0) return 2;
        if (a ==? 10'b1001_1010_10) return 4;
        return 0;
    endfunction

    always @(posedge clk_h or posedge reset_h) begin
        if (reset_h) begin
            m_rem = 0; m_mul = 1'b0; m_div = 1'b0; m_isrem = 1'b0;
        end else if (abort_h) begin
            m_rem = 0;
        end else if (!stall_h) begin
            if (m_rem == 0) begin
                if (uvalid_h && alu_0xxx_l) begin
                    m_kind = op_kind(alpctl_h);
                    if (m_kind == 1 || m_kind == 2) begin
                        m_mul = (m_kind == 1); m_div = (m_kind == 2); m_isrem = 1'b0;
                        m_rem = alpctl_h[1] ? WIDTH : WIDTH / FAST_BITS;
                    end else if (m_kind == 4) begin
                        m_mul = 1'b0; m_div = 1'b0; m_isrem = 1'b1; m_rem = 1;
                    end
                end
            end else if (EARLY && m_mul && mdr_zero_h && m_rem > 1) begin
                m_rem = 1;
            end else begin
                m_rem = m_rem - 1;
            end
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk_h) begin
        if (cmp_en && !reset_h) begin
            chk("cyc_busy", 32'(busy_h), 32'(m_rem > 0));
            chk("cyc_loop_flag", 32'(loop_flag_h), 32'(!m_isrem && m_rem > 1));
            chk("cyc_last_iter", 32'(last_iter_h), 32'(!m_isrem && m_rem == 1));
            chk("cyc_fix", 32'(fix_h), 32'(m_isrem && m_rem == 1));
            chk("cyc_iter_cnt", 32'(iter_cnt_h), (m_rem > 0 && !m_isrem) ? 32'(m_rem - 1) : 32'd0);
            chk("cyc_shl", 32'(shl_op_h), 32'(alu_shl_op_h | (m_div && m_rem > 0)
                | (uvalid_h && alu_0xxx_l && m_rem == 0 && op_kind(alpctl_h) == 3)));
            chk("cyc_shr", 32'(shr_op_h), 32'(alu_shr_op_h | (m_mul && m_rem > 0)));
        end
    end

    // Driver tasks: inputs change 2 time units after the falling edge.
    task automatic tick();
        @(negedge clk_h);
        #2;
    endtask

    task automatic idle_inputs();
        alpctl_h = '0; alu_0xxx_l = 1'b1; alu_shl_op_h = 1'b0; alu_shr_op_h = 1'b0;
        uvalid_h = 1'b0; stall_h = 1'b0; abort_h = 1'b0; mdr_zero_h = 1'b0;
    endtask

    task automatic issue(input logic [9:0] op);
        alpctl_h = op; uvalid_h = 1'b1;
        tick();
        alpctl_h = '0; uvalid_h = 1'b0;
    endtask

    int r_busy, r_lf, r_last_n, r_last_at, r_first, r_shl, r_shr, r_fix, r_hold;

    // Issue one op and observe it until busy drops, with an optional stall and mdr_zero pulse.
    task automatic run_loop(input logic [9:0] op, input int stall_at, input int stall_len,
                            input int mdr_at);
        int stalls_left;
        bit stall_done;
        int guard;
        r_busy = 0; r_lf = 0; r_last_n = 0; r_last_at = 0; r_shl = 0; r_shr = 0;
        r_fix = 0; r_hold = 0;
        issue(op);
        r_first = int'(iter_cnt_h);
        stalls_left = 0; stall_done = 1'b0; guard = 0;
        while (busy_h === 1'b1 && guard < 100) begin
            guard++;
            r_busy++;
            if (loop_flag_h) r_lf++;
            if (last_iter_h) begin r_last_n++; r_last_at = r_busy; end
            if (fix_h) r_fix++;
            if (shl_op_h) r_shl++;
            if (shr_op_h) r_shr++;
            if (int'(iter_cnt_h) == stall_at) r_hold++;
            if (exp_q.size() > 0 && !stall_h) chk("div_cnt_seq", 32'(iter_cnt_h), 32'(exp_q.pop_front()));
            stall_h = 1'b0; mdr_zero_h = 1'b0;
            if (!stall_done && int'(iter_cnt_h) == stall_at && loop_flag_h) begin
                stall_done = 1'b1; stalls_left = stall_len;
            end
            if (stalls_left > 0) begin stall_h = 1'b1; stalls_left--; end
            if (int'(iter_cnt_h) == mdr_at && loop_flag_h && !stall_h) mdr_zero_h = 1'b1;
            tick();
        end
        stall_h = 1'b0; mdr_zero_h = 1'b0;
        chk("loop_timeout", 32'(guard < 100), 32'd1);
    endtask

    int guard2;

    initial begin
        idle_inputs();
        reset_h = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy_h), 32'd0);
        chk("rst_iter", 32'(iter_cnt_h), 32'd0);
        chk("rst_flags", 32'({loop_flag_h, last_iter_h, fix_h, shl_op_h, shr_op_h}), 32'd0);
        reset_h = 1'b0; cmp_en = 1'b1;
        tick();

        // MUL fast: 16 busy cycles, 15 loop-flag cycles, last on cycle 16, shr throughout.
        run_loop(10'h269, -1, 0, -1);
        chk("mul_busy", 32'(r_busy), 32'd16);
        chk("mul_loop_flag", 32'(r_lf), 32'd15);
        chk("mul_last_at", 32'(r_last_at), 32'd16);
        chk("mul_last_n", 32'(r_last_n), 32'd1);
        chk("mul_first_cnt", 32'(r_first), 32'd15);
        chk("mul_shr", 32'(r_shr), 32'd16);
        chk("mul_shl", 32'(r_shl), 32'd0);
        tick();

        // DIV slow: 32 busy cycles, counter runs 31 down to 0, shl throughout.
        for (int i = 31; i >= 0; i--) exp_q.push_back(CNT_W'(i));
        run_loop(10'h27E, -1, 0, -1);
        chk("div_busy", 32'(r_busy), 32'd32);
        chk("div_shl", 32'(r_shl), 32'd32);
        chk("div_shr", 32'(r_shr), 32'd0);
        chk("div_first_cnt", 32'(r_first), 32'd31);
        chk("div_seq_done", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();

        // Stall for 3 cycles at count 8: count holds and the loop ends 3 cycles late.
        run_loop(10'h269, 8, 3, -1);
        chk("stall_busy", 32'(r_busy), 32'd19);
        chk("stall_hold8", 32'(r_hold), 32'd4);
        chk("stall_last_n", 32'(r_last_n), 32'd1);
        tick();

        // REM: a single fix-up cycle.
        run_loop(10'h26A, -1, 0, -1);
        chk("rem_busy", 32'(r_busy), 32'd1);
        chk("rem_fix", 32'(r_fix), 32'd1);
        chk("rem_loop_flag", 32'(r_lf + r_last_n), 32'd0);
        tick();

        // mdr_zero at count 10 on a fast MUL.
        run_loop(10'h269, -1, 0, 10);
        chk("early_busy", 32'(r_busy), EARLY ? 32'd7 : 32'd16);
        chk("early_last_n", 32'(r_last_n), 32'd1);
        tick();

        // Asynchronous reset at count 5 clears every output immediately.
        issue(10'h269);
        guard2 = 0;
        while (int'(iter_cnt_h) != 5 && guard2 < 40) begin guard2++; tick(); end
        chk("rst5_reached", 32'(iter_cnt_h), 32'd5);
        reset_h = 1'b1;
        #1;
        chk("rst5_busy", 32'(busy_h), 32'd0);
        chk("rst5_iter", 32'(iter_cnt_h), 32'd0);
        chk("rst5_flags", 32'({loop_flag_h, last_iter_h, fix_h, shl_op_h, shr_op_h}), 32'd0);
        tick();
        reset_h = 1'b0;
        tick();
        chk("rst5_idle", 32'(busy_h), 32'd0);

        // Abort in the middle of a DIV loop returns to IDLE.
        issue(10'h27E);
        tick(); tick();
        abort_h = 1'b1;
        tick();
        abort_h = 1'b0;
        chk("abort_busy", 32'(busy_h), 32'd0);
        chk("abort_iter", 32'(iter_cnt_h), 32'd0);
        chk("abort_shl", 32'(shl_op_h), 32'd0);

        // Abort outranks a simultaneous issue.
        alpctl_h = 10'h269; uvalid_h = 1'b1; abort_h = 1'b1;
        tick();
        idle_inputs();
        chk("abort_vs_issue", 32'(busy_h), 32'd0);

        // Decode is gated by alu_0xxx_l.
        alpctl_h = 10'h269; uvalid_h = 1'b1; alu_0xxx_l = 1'b0;
        tick();
        idle_inputs();
        chk("alu0xxx_gate", 32'(busy_h), 32'd0);

        // DIVD: shl is asserted combinationally and busy stays low.
        alpctl_h = 10'h27F; uvalid_h = 1'b1;
        #1;
        chk("divd_shl", 32'(shl_op_h), 32'd1);
        tick();
        chk("divd_busy", 32'(busy_h), 32'd0);
        idle_inputs();

        // ALU pass-through terms.
        alu_shl_op_h = 1'b1;
        #1;
        chk("pass_shl", 32'({shl_op_h, shr_op_h}), 32'd2);
        alu_shl_op_h = 1'b0; alu_shr_op_h = 1'b1;
        #1;
        chk("pass_shr", 32'({shl_op_h, shr_op_h}), 32'd1);
        tick();
        idle_inputs();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
